sp1_ram: RTL and testbench
==========================

// Module: sp1_ram
// PURPOSE
//   Single-port synchronous RAM of 64 words x 32 bits for the sp1 core (heap/stack store).
//   - Chip-select gated; one access per clock, read or write.
//   - Registered read data with 1-cycle latency; used directly by the sp1 memory stage.
// PARAMETERS
//   AW     6              address width; depth = 2**AW words
//   DW     32             data word width
//   DEPTH  (1<<AW) = 64   number of words; derived, not to be overridden
// PORTS
//   clk   in   1    clock; all state changes on rising edge
//   rst   in   1    reset; asynchronous, active-low (rst==0 resets)
//   cs    in   1    chip select; access performed only when 1
//   we    in   1    write enable (1 = write, 0 = read); qualified by cs
//   adr   in   AW   word address, 0..63
//   din   in   DW   write data
//   dout  out  DW   registered read data
// BEHAVIOUR
//   - Reset (rst==0, async):
//     - dout <= 0 immediately; every mem word <= 0.
//     - Held while rst==0; all accesses ignored.
//   - First usable edge: first rising clk after rst rises.
//   - Write (cs=1, we=1 at posedge): mem[adr] <= din.
//     - dout unchanged (see CONFIGURATION).
//   - Read (cs=1, we=0 at posedge): dout <= mem[adr].
//     - Valid 1 cycle after the request edge.
//     - dout then holds until the next read or reset.
//   - Idle (cs=0): no state change; dout holds.
//     - we/adr/din may be X while cs=0 and must never corrupt mem or dout.
//   - Read of a never-written word after reset returns 32'h0.
//   - Back-to-back write then read of same adr: read returns new data.
//     - Write completes at the earlier edge.
//   - Address 63 is valid; addresses wrap naturally (no out-of-range case with AW=6).
//   - No combinational path from any input to dout.
// CONFIGURATION
//   SP1_RAM_WRITE_THROUGH_EN
//     - defined:   a write cycle also sets dout <= din on the same edge (write-first).
//     - undefined: dout holds its previous value on write cycles.
// STRUCTURE
//   - sp1_common.h: SP1_RAM_AW=6, SP1_RAM_DW=32, SP1_RAM_DEPTH=64 constants, used by the core too.
//   - Sub-module sp1_ram_array:
//     - reg array with async clear and write port.
//     - Provides a combinational read mux by address.
//   - sp1_ram itself: access decode (cs/we) and the dout register.
// TESTING
//   - Reset: rst=0 for 5 clocks -> dout==0; then read adr 00 -> dout==32'h0.
//   - Write adr 01 <- 32'h12345678, then read adr 01 -> dout==32'h12345678 one edge after the request.
//   - Write 3f <- 32'hdeadbeef and 00 <- 32'hcafef00d; read 3f then 00 -> correct values, no aliasing.
//   - Idle with cs=0 and we/adr/din=X for 5 clocks -> dout holds last value, mem intact.
//   - Mid-run reset: after writes, pulse rst=0 between edges -> dout drops to 0 at once; reads return 0.
//   - Write adr 05 <- 32'hA5A5A5A5 with the previous read returning 32'h1:
//     - without SP1_RAM_WRITE_THROUGH_EN -> dout stays 32'h1;
//     - with it defined -> dout==32'hA5A5A5A5.

Source files
------------

// File: rtl/sp1_ram_pkg.sv
// -----------------------------------------------------------------------------
// sp1_ram_pkg
//   Shared constants and access-decode helpers for the sp1 data RAM.
//   SP1_RAM_AW / SP1_RAM_DW / SP1_RAM_DEPTH are also used by the sp1 core so
//   that both sides agree on the memory geometry.
//   Contents:
//     SP1_RAM_AW, SP1_RAM_DW, SP1_RAM_DEPTH  geometry constants
//     access_e                              decoded access kind for one cycle
//     decode_access()                       cs/we -> access_e
// -----------------------------------------------------------------------------
package sp1_ram_pkg;

    localparam int SP1_RAM_AW    = 6;
    localparam int SP1_RAM_DW    = 32;
    localparam int SP1_RAM_DEPTH = 1 << SP1_RAM_AW;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } access_e;

    // cs is tested first so that an undefined we while deselected always
    // decodes to idle and can never reach the array or the output register.
    function automatic access_e decode_access(input logic cs, input logic we);
        access_e acc;
        acc = ACC_IDLE;
        if (cs === 1'b1) begin
            if (we === 1'b1) begin
                acc = ACC_WRITE;
            end else if (we === 1'b0) begin
                acc = ACC_READ;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/sp1_ram_array.sv
// -----------------------------------------------------------------------------
// sp1_ram_array
//   Register-based storage for sp1_ram: DEPTH words of DW bits with an
//   asynchronous clear, one synchronous write port and a combinational read
//   mux selected by address.
//   Ports:
//     clk      in   1    clock, writes on rising edge
//     rst      in   1    asynchronous active-low clear of every word
//     wr_en    in   1    write strobe (already qualified by chip select)
//     wr_adr   in   AW   write address
//     wr_data  in   DW   write data
//     rd_adr   in   AW   read address
//     rd_data  out  DW   combinational read data, mem[rd_adr]
// -----------------------------------------------------------------------------
module sp1_ram_array
    import sp1_ram_pkg::*;
#(
    parameter int AW = SP1_RAM_AW,
    parameter int DW = SP1_RAM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_adr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_adr,
    output logic [DW-1:0] rd_data
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // Every word is cleared by reset so a read of a never-written location
    // returns zero, which the core relies on for a clean heap/stack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_adr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_adr];

endmodule

// File: rtl/sp1_ram.sv
// -----------------------------------------------------------------------------
// sp1_ram
//   Single-port synchronous RAM, 64 x 32, for the sp1 core heap/stack.
//   One access per clock selected by cs/we; read data is registered, so it
//   appears on dout one cycle after the request edge and then holds until the
//   next read or reset. There is no combinational path from inputs to dout.
//   Ports:
//     clk   in   1    clock
//     rst   in   1    asynchronous active-low reset (clears dout and memory)
//     cs    in   1    chip select
//     we    in   1    write enable, 1 = write, 0 = read (qualified by cs)
//     adr   in   AW   word address
//     din   in   DW   write data
//     dout  out  DW   registered read data
//   Build option:
//     SP1_RAM_WRITE_THROUGH_EN  when defined, a write also loads din into dout
//                               on the same edge (write-first); otherwise dout
//                               holds on write cycles.
// -----------------------------------------------------------------------------
module sp1_ram
    import sp1_ram_pkg::*;
#(
    parameter int AW = SP1_RAM_AW,
    parameter int DW = SP1_RAM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic          we,
    input  logic [AW-1:0] adr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    access_e       acc;
    logic          wr_en;
    logic [DW-1:0] rd_data;

    assign acc   = decode_access(cs, we);
    assign wr_en = (acc == ACC_WRITE);

    sp1_ram_array #(
        .AW (AW),
        .DW (DW)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_adr  (adr),
        .wr_data (din),
        .rd_adr  (adr),
        .rd_data (rd_data)
    );

    // Output register. On a read it captures the array word as it was before
    // the edge; a write to the same address on this edge is not possible since
    // the port does one access per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= '0;
        end else if (acc == ACC_READ) begin
            dout <= rd_data;
`ifdef SP1_RAM_WRITE_THROUGH_EN
        end else if (acc == ACC_WRITE) begin
            dout <= din;
`endif
        end
    end

endmodule

// File: tb/tb_sp1_ram.sv
// -----------------------------------------------------------------------------
// tb_sp1_ram
//   Self-checking bench for sp1_ram. A plain array model of the memory plus
//   the expected dout value is updated per access and compared to the DUT
//   after every rising edge, and also just before it to catch any path from
//   the inputs straight to dout.
//   Honours SP1_RAM_WRITE_THROUGH_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_sp1_ram;
    import sp1_ram_pkg::*;

    localparam int AW = SP1_RAM_AW;
    localparam int DW = SP1_RAM_DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;

    int errCount   = 0;
    int checkCount = 0;

    logic [DW-1:0] refMem [SP1_RAM_DEPTH];
    logic [DW-1:0] refDout;

    always #5 clk = ~clk;

    sp1_ram dut (
        .clk  (clk),
        .rst  (rst),
        .cs   (cs),
        .we   (we),
        .adr  (adr),
        .din  (din),
        .dout (dout)
    );

    task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: dout=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < SP1_RAM_DEPTH; i++) begin
            refMem[i] = '0;
        end
        refDout = '0;
    endfunction

    // One bus cycle: drive at the falling edge, confirm dout has not moved,
    // let the rising edge happen, update the model, then compare.
    task automatic applyStimulus(input logic c, input logic w, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input string tag);
        @(negedge clk);
        cs  = c;
        we  = w;
        adr = a;
        din = d;
        #1 checkOutput({tag, "/pre"}, dout, refDout);
        @(posedge clk);
        if (c === 1'b1) begin
            if (w === 1'b1) begin
                refMem[a] = d;
`ifdef SP1_RAM_WRITE_THROUGH_EN
                refDout = d;
`endif
            end else begin
                refDout = refMem[a];
            end
        end
        #1 checkOutput(tag, dout, refDout);
    endtask

    // Asserts reset between edges with the port deselected; dout must clear
    // immediately rather than on the next clock.
    task automatic pulseReset();
        @(negedge clk);
        cs = 1'b0;
        #1 rst = 1'b0;
        #1 checkOutput("async_reset", dout, '0);
        modelReset();
        #1 rst = 1'b1;
    endtask

    logic [DW-1:0] expWt;

    initial begin
        rst = 1'b0;
        cs  = 1'b1;
        we  = 1'b1;
        adr = '0;
        din = 32'hFFFF_FFFF;
        modelReset();

        // Held in reset for 5 clocks with a write pending: nothing may change.
        repeat (5) begin
            @(posedge clk);
            #1 checkOutput("reset_hold", dout, '0);
        end
        @(negedge clk);
        cs  = 1'b0;
        rst = 1'b1;

        applyStimulus(1'b1, 1'b0, 6'h00, '0, "read_after_reset");
        checkOutput("read_00_zero", dout, 32'h0);

        applyStimulus(1'b1, 1'b1, 6'h01, 32'h1234_5678, "wr_01");
        applyStimulus(1'b1, 1'b0, 6'h01, '0, "rd_01");
        checkOutput("rd_01_value", dout, 32'h1234_5678);

        applyStimulus(1'b1, 1'b1, 6'h3f, 32'hDEAD_BEEF, "wr_3f");
        applyStimulus(1'b1, 1'b1, 6'h00, 32'hCAFE_F00D, "wr_00");
        applyStimulus(1'b1, 1'b0, 6'h3f, '0, "rd_3f");
        checkOutput("rd_3f_value", dout, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b0, 6'h00, '0, "rd_00");
        checkOutput("rd_00_value", dout, 32'hCAFE_F00D);

        // Deselected with undefined controls, then with random junk.
        repeat (5) applyStimulus(1'b0, 1'bx, 'x, 'x, "idle_x");
        checkOutput("idle_x_hold", dout, 32'hCAFE_F00D);
        repeat (5) applyStimulus(1'b0, 1'($urandom), 6'($urandom), $urandom, "idle_junk");
        applyStimulus(1'b1, 1'b0, 6'h01, '0, "rd_01_after_idle");
        checkOutput("mem_intact_01", dout, 32'h1234_5678);
        applyStimulus(1'b1, 1'b0, 6'h3f, '0, "rd_3f_after_idle");

        pulseReset();
        applyStimulus(1'b1, 1'b0, 6'h3f, '0, "rd_3f_after_rst");
        checkOutput("rst_clears_3f", dout, 32'h0);
        applyStimulus(1'b1, 1'b0, 6'h01, '0, "rd_01_after_rst");
        checkOutput("rst_clears_01", dout, 32'h0);

        // Write while dout holds a known non-zero read value.
        applyStimulus(1'b1, 1'b1, 6'h07, 32'h0000_0001, "wr_07");
        applyStimulus(1'b1, 1'b0, 6'h07, '0, "rd_07");
        applyStimulus(1'b1, 1'b1, 6'h05, 32'hA5A5_A5A5, "wr_05");
`ifdef SP1_RAM_WRITE_THROUGH_EN
        expWt = 32'hA5A5_A5A5;
`else
        expWt = 32'h0000_0001;
`endif
        checkOutput("write_dout_policy", dout, expWt);
        applyStimulus(1'b1, 1'b0, 6'h05, '0, "rd_05");
        checkOutput("rd_05_value", dout, 32'hA5A5_A5A5);

        // Random traffic, biased toward the address extremes.
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] a;
            case ($urandom_range(0, 5))
                0:       a = 6'h00;
                1:       a = 6'h3f;
                default: a = 6'($urandom);
            endcase
            applyStimulus(($urandom_range(0, 9) < 8), 1'($urandom), a, $urandom, "random");
            if (n == 200) pulseReset();
        end

        // Final sweep confirms every word against the model.
        for (int i = 0; i < SP1_RAM_DEPTH; i++) begin
            applyStimulus(1'b1, 1'b0, 6'(i), '0, "sweep");
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
